conv_accumulate: RTL

//   Downstream neighbour of the 5x5 tap multiplier. Takes the 25 signed tap products of one

---
 rtl/cnn_pkg.sv | 33 +++
 rtl/row_sum5.sv | 31 +++
 rtl/conv_accumulate.sv | 91 +++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the convolution datapath blocks.
// Provides tap counts, the accumulator width rule and signed saturation.
package cnn_pkg;

  localparam int NUM_TAPS  = 25;
  localparam int ROW_TAPS  = 5;
  localparam int SAT_MAX_W = 128;

  // Five extra bits cover the growth of 25 products plus one bias term.
  function automatic int acc_w(input int in_width);
    return in_width + 5;
  endfunction

  // Clamp a wide signed value into the signed range of out_w bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat_to_width(
    input logic signed [SAT_MAX_W-1:0] val,
    input int                          out_w
  );
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    max_v = '0;
    max_v[out_w-1] = 1'b1;
    max_v = max_v - SAT_MAX_W'(1);
    min_v = ~max_v;
    if (val > max_v)
      return max_v;
    else if (val < min_v)
      return min_v;
    else
      return val;
  endfunction

endpackage

// File: rtl/row_sum5.sv
// Registered sum of five signed taps, each sign-extended to the accumulator width.
// Loads only when en is high so the surrounding pipeline can stall as a unit.
module row_sum5
  import cnn_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int ACC_W    = 37
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [IN_WIDTH*ROW_TAPS-1:0]  taps,
  output logic signed [ACC_W-1:0]       sum
);

  logic signed [ACC_W-1:0] sum_next;

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < ROW_TAPS; k++)
      sum_next = sum_next + ACC_W'($signed(taps[IN_WIDTH*k +: IN_WIDTH]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum <= '0;
    else if (en)
      sum <= sum_next;
  end

endmodule

// File: rtl/conv_accumulate.sv
// Sums 25 tap products plus bias in a 3-stage stallable pipeline and saturates the result.
// Optional feature macro CONV_ACC_RELU_EN clamps negative outputs to zero after saturation.
module conv_accumulate
  import cnn_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int BIAS_WIDTH = 16,
  parameter int FMAP_PIX   = 576
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH*NUM_TAPS-1:0]  prod_in,
  input  logic [BIAS_WIDTH-1:0]         bias,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [OUT_WIDTH-1:0]          pixel_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last
);

  localparam int ACC_W = acc_w(IN_WIDTH);
  localparam int CNT_W = (FMAP_PIX > 1) ? $clog2(FMAP_PIX) : 1;
  localparam int ROW_W = IN_WIDTH * ROW_TAPS;

  logic                    adv;
  logic                    v1;
  logic                    v2;
  logic signed [ACC_W-1:0] row_sum [ROW_TAPS];
  logic signed [ACC_W-1:0] bias_s1;
  logic signed [ACC_W-1:0] total;
  logic [OUT_WIDTH-1:0]    pixel_next;
  logic [CNT_W-1:0]        pix_cnt;
  logic                    cnt_at_end;

  // Global stall: every stage moves only when the output slot is free or draining.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar i = 0; i < ROW_TAPS; i++) begin : g_row
    row_sum5 #(
      .IN_WIDTH (IN_WIDTH),
      .ACC_W    (ACC_W)
    ) u_row (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .taps (prod_in[ROW_W*i +: ROW_W]),
      .sum  (row_sum[i])
    );
  end

  always_comb begin
    pixel_next = OUT_WIDTH'(sat_to_width(SAT_MAX_W'(total), OUT_WIDTH));
`ifdef CONV_ACC_RELU_EN
    if (pixel_next[OUT_WIDTH-1])
      pixel_next = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      bias_s1   <= '0;
      total     <= '0;
      pixel_out <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      bias_s1   <= ACC_W'($signed(bias));
      v2        <= v1;
      total     <= row_sum[0] + row_sum[1] + row_sum[2] + row_sum[3] + row_sum[4] + bias_s1;
      out_valid <= v2;
      pixel_out <= pixel_next;
    end
  end

  assign cnt_at_end = (pix_cnt == CNT_W'(FMAP_PIX - 1));
  assign out_last   = out_valid & cnt_at_end;

  // Counts delivered pixels so the last one of each feature map can be flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pix_cnt <= '0;
    else if (out_valid && out_ready)
      pix_cnt <= cnt_at_end ? '0 : pix_cnt + CNT_W'(1);
  end

endmodule
